sys_mem_ctrl: RTL

Parametrised memory and MMIO slave for the picorv32 native memory bus, sitting directly behind the core or the cache. It provides a word-addressed on-chip RAM with configurable read latency, byte-strobed writes, and NUM_OUT independent byte-output channels. Each channel is buffered by a FIFO with a valid/ready drain interface. Unmapped accesses complete with an error pulse, so the bus never hangs.

---
 rtl/sys_mem_pkg.sv | 37 +++
 rtl/sys_mem_ctrl_byte_fifo.sv | 76 +++++++
 rtl/sys_mem_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_mem_pkg.sv
// Shared types and constants for the picorv32 memory/MMIO slave.
// Holds the FSM and decode enums, the status word layout and the default channel base.
package sys_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_WAIT  = 2'd1,
      ST_OUT_WAIT = 2'd2,
      ST_RESP     = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      DEC_RAM      = 2'd0,
      DEC_CHAN     = 2'd1,
      DEC_UNMAPPED = 2'd2
   } decode_e;

   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_COUNT_W   = 8;

   localparam logic [31:0] DEFAULT_OUT_BASE = 32'h1000_0000;

   // Channel status word: {16'b0, count[7:0], 6'b0, full, empty}
   function automatic logic [31:0] status_word(input logic [7:0] count,
                                               input logic       full,
                                               input logic       empty);
      logic [31:0] w;
      w                                       = 32'd0;
      w[STAT_COUNT_LSB +: STAT_COUNT_W]       = count;
      w[STAT_FULL_BIT]                        = full;
      w[STAT_EMPTY_BIT]                       = empty;
      return w;
   endfunction

endpackage

// File: rtl/sys_mem_ctrl_byte_fifo.sv
// Byte FIFO for one output channel; full/empty derive from the registered count only,
// so a pop never makes room for a push in the same cycle.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    push,
   input  logic [7:0]              din,
   input  logic                    pop,
   output logic [7:0]              dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW    = $clog2(DEPTH);
   localparam int CNT_W = PW + 1;

   logic [7:0]       mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Pointer and occupancy next-state
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_ok_s) begin
         wr_d = wr_q + PW'(1'b1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_ok_s) begin
         rd_d = rd_q + PW'(1'b1);
      end else begin
         rd_d = rd_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage, pointers and count registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_q  <= {PW{1'b0}};
         rd_q  <= {PW{1'b0}};
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) begin
            mem_q[wr_q] <= din;
         end
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == {CNT_W{1'b0}});
   assign count = cnt_q;

endmodule

// File: rtl/sys_mem_ctrl.sv
// Memory and MMIO slave for the picorv32 native bus: on-chip RAM with configurable read
// latency plus NUM_OUT FIFO-buffered byte output channels; unmapped accesses error out.
module sys_mem_ctrl
   import sys_mem_pkg::*;
#(
   parameter int          MEM_WORDS    = 4096,
   parameter int          READ_LATENCY = 2,
   parameter int          NUM_OUT      = 2,
   parameter logic [31:0] OUT_BASE     = DEFAULT_OUT_BASE,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   mem_valid,
   output logic                   mem_ready,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_wdata,
   input  logic [3:0]             mem_wstrb,
   output logic [31:0]            mem_rdata,
   output logic [8*NUM_OUT-1:0]   out_data,
   output logic [NUM_OUT-1:0]     out_valid,
   input  logic [NUM_OUT-1:0]     out_ready,
   output logic                   err_unmapped
);

   localparam int AW    = $clog2(MEM_WORDS);
   localparam int CW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q, state_d;
   logic [1:0]        wait_q, wait_d;
   logic [AW-1:0]     word_q, word_d;
   logic [7:0]        byte_q, byte_d;
   logic [CW-1:0]     chan_q, chan_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [31:0]       ram_q [MEM_WORDS];
   logic [31:0]       ram_dout_q;
   logic [AW-1:0]     rd_idx_s;
   logic              ram_we_s;

   decode_e           dec_s;
   logic [CW-1:0]     dec_chan_s;
   logic [31:0]       chan_off_s;
   logic              is_write_s;

   logic [NUM_OUT-1:0] push_s;
   logic [NUM_OUT-1:0] pop_s;
   logic [NUM_OUT-1:0] fifo_full_s;
   logic [NUM_OUT-1:0] fifo_empty_s;
   logic [CNT_W-1:0]   fifo_cnt_s [NUM_OUT];
   logic               push_any_s;
   logic [7:0]         push_byte_s;
   logic [CW-1:0]      push_chan_s;

   assign chan_off_s = mem_addr - OUT_BASE;
   assign is_write_s = |mem_wstrb;

   // Address decode of the live bus request
   always_comb begin
      dec_s      = DEC_UNMAPPED;
      dec_chan_s = {CW{1'b0}};
      if ((mem_addr < OUT_BASE) && (mem_addr[31:2] < 30'(MEM_WORDS))) begin
         dec_s = DEC_RAM;
      end else if ((mem_addr >= OUT_BASE) && (chan_off_s[1:0] == 2'b00) &&
                   (chan_off_s[31:2] < 30'(NUM_OUT))) begin
         dec_s      = DEC_CHAN;
         dec_chan_s = chan_off_s[CW+1:2];
      end else begin
         dec_s = DEC_UNMAPPED;
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         wait_q  <= 2'd0;
         word_q  <= {AW{1'b0}};
         byte_q  <= 8'h00;
         chan_q  <= {CW{1'b0}};
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         word_q  <= word_d;
         byte_q  <= byte_d;
         chan_q  <= chan_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // FSM next-state; the request is captured at acceptance and the bus ignored afterwards
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      word_d      = word_q;
      byte_d      = byte_q;
      chan_d      = chan_q;
      rdata_d     = rdata_q;
      err_d       = 1'b0;
      ram_we_s    = 1'b0;
      push_any_s  = 1'b0;
      push_byte_s = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               word_d  = mem_addr[AW+1:2];
               byte_d  = mem_wdata[7:0];
               chan_d  = dec_chan_s;
               rdata_d = 32'd0;
               case (dec_s)
                  DEC_RAM: begin
                     if (is_write_s) begin
                        ram_we_s = 1'b1;
                        state_d  = ST_RESP;
                     end else begin
                        wait_d  = 2'(READ_LATENCY - 1);
                        state_d = ST_RD_WAIT;
                     end
                  end
                  DEC_CHAN: begin
                     if (!is_write_s) begin
                        rdata_d = status_word(8'(fifo_cnt_s[dec_chan_s]),
                                              fifo_full_s[dec_chan_s],
                                              fifo_empty_s[dec_chan_s]);
                        state_d = ST_RESP;
                     end else if (!mem_wstrb[0]) begin
                        state_d = ST_RESP;
                     end else if (!fifo_full_s[dec_chan_s]) begin
                        push_any_s  = 1'b1;
                        push_byte_s = mem_wdata[7:0];
                        state_d     = ST_RESP;
                     end else begin
                        state_d = ST_OUT_WAIT;
                     end
                  end
                  default: begin
                     err_d   = 1'b1;
                     state_d = ST_RESP;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (wait_q == 2'd0) begin
               rdata_d = ram_dout_q;
               state_d = ST_RESP;
            end else begin
               wait_d = wait_q - 2'd1;
            end
         end
         ST_OUT_WAIT: begin
            if (!fifo_full_s[chan_q]) begin
               push_any_s  = 1'b1;
               push_byte_s = byte_q;
               state_d     = ST_RESP;
            end else begin
               state_d = ST_OUT_WAIT;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Bus outputs decoded from registered state
   always_comb begin
      mem_ready    = (state_q == ST_RESP);
      mem_rdata    = rdata_q;
      err_unmapped = err_q;
   end

   assign rd_idx_s = (state_q == ST_IDLE) ? mem_addr[AW+1:2] : word_q;

   // RAM array: not reset, contents come from the firmware image load flow
   always_ff @(posedge clk) begin
      if (ram_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) begin
               ram_q[mem_addr[AW+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
      ram_dout_q <= ram_q[rd_idx_s];
   end

   assign push_chan_s = (state_q == ST_IDLE) ? dec_chan_s : chan_q;

   // Route the single push strobe to the addressed channel
   always_comb begin
      push_s = {NUM_OUT{1'b0}};
      for (int k = 0; k < NUM_OUT; k++) begin
         if (push_any_s && (push_chan_s == CW'(k))) begin
            push_s[k] = 1'b1;
         end else begin
            push_s[k] = 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_chan
      assign pop_s[k] = ~fifo_empty_s[k] & out_ready[k];

      byte_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk    (clk),
         .resetn (resetn),
         .push   (push_s[k]),
         .din    (push_byte_s),
         .pop    (pop_s[k]),
         .dout   (out_data[8*k +: 8]),
         .full   (fifo_full_s[k]),
         .empty  (fifo_empty_s[k]),
         .count  (fifo_cnt_s[k])
      );
   end

   assign out_valid = ~fifo_empty_s;

endmodule
